// File: rtl/boid_pkg.sv
// Shared types and constants for the boid raster engine.
package boid_pkg;

    localparam int VIDEO_WIDTH_DEF  = 640;
    localparam int VIDEO_HEIGHT_DEF = 480;

    function automatic int addr_w(input int width, input int height);
        return $clog2(width * height);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;

endpackage

// File: rtl/boid_addr_gen.sv
// Linear framebuffer address and bounds flag for one boid pixel (x+dx, y+dy).
module boid_addr_gen
    import boid_pkg::*;
#(
    parameter int VIDEO_WIDTH  = VIDEO_WIDTH_DEF,
    parameter int VIDEO_HEIGHT = VIDEO_HEIGHT_DEF,
    parameter int ADDR_W       = addr_w(VIDEO_WIDTH, VIDEO_HEIGHT)
) (
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic [1:0]        i_dx,
    input  logic [1:0]        i_dy,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_bounds
);

    localparam logic [31:0] W32 = VIDEO_WIDTH;
    localparam logic [31:0] H32 = VIDEO_HEIGHT;

    // 11-bit sums so a boid near 1023/511 lands off-screen instead of wrapping to 0
    logic [10:0] w_xs;
    logic [10:0] w_ys;

    assign w_xs = {1'b0, i_x} + {9'd0, i_dx};
    assign w_ys = {2'b0, i_y} + {9'd0, i_dy};

    assign o_in_bounds = ({21'd0, w_xs} < W32) && ({21'd0, w_ys} < H32);
    assign o_addr      = ADDR_W'(w_ys) * ADDR_W'(VIDEO_WIDTH) + ADDR_W'(w_xs);

endmodule

// File: rtl/boid_raster_engine.sv
// Clears the back buffer, draws one square per valid boid, then flips buffers.
// Double buffering is enabled by defining BOID_DOUBLE_BUFFER_EN.
module boid_raster_engine
    import boid_pkg::*;
#(
    parameter int MAX_BOIDS    = 8,
    parameter int BOID_SIZE    = 2,
    parameter int VIDEO_WIDTH  = VIDEO_WIDTH_DEF,
    parameter int VIDEO_HEIGHT = VIDEO_HEIGHT_DEF,
    localparam int ADDR_W      = addr_w(VIDEO_WIDTH, VIDEO_HEIGHT)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_frame_end,
    input  logic [MAX_BOIDS*10-1:0] i_boid_x,
    input  logic [MAX_BOIDS*9-1:0]  i_boid_y,
    input  logic [MAX_BOIDS-1:0]    i_boid_valid,
    output logic                   o_fb_we,
    output logic [ADDR_W-1:0]      o_fb_waddr,
    output logic                   o_fb_wdata,
    output logic                   o_fb_wbuf,
    output logic                   o_disp_buf,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_overrun
);

    localparam int                BIDX_W    = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VIDEO_WIDTH * VIDEO_HEIGHT - 1);
    localparam logic [BIDX_W-1:0] LAST_IDX  = BIDX_W'(MAX_BOIDS - 1);
    localparam logic [1:0]        LAST_D    = 2'(BOID_SIZE - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [MAX_BOIDS*10-1:0] r_bx;
    logic [MAX_BOIDS*9-1:0]  r_by;
    logic [MAX_BOIDS-1:0]    r_bv;
    logic [ADDR_W-1:0]       r_clr_addr;
    logic [BIDX_W-1:0]       r_idx;
    logic [1:0]              r_dx;
    logic [1:0]              r_dy;
    logic                    r_overrun;

    logic [9:0]        w_cur_x;
    logic [8:0]        w_cur_y;
    logic              w_cur_v;
    logic [ADDR_W-1:0] w_pix_addr;
    logic              w_pix_in;
    logic              w_last_pix;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic              w_data;
    logic              w_done;

    assign w_cur_x    = r_bx[int'(r_idx)*10 +: 10];
    assign w_cur_y    = r_by[int'(r_idx)*9 +: 9];
    assign w_cur_v    = r_bv[r_idx];
    // an invalid boid occupies a single slot instead of the full square
    assign w_last_pix = !w_cur_v || ((r_dx == LAST_D) && (r_dy == LAST_D));

    boid_addr_gen #(
        .VIDEO_WIDTH  (VIDEO_WIDTH),
        .VIDEO_HEIGHT (VIDEO_HEIGHT),
        .ADDR_W       (ADDR_W)
    ) u_addr_gen (
        .i_x         (w_cur_x),
        .i_y         (w_cur_y),
        .i_dx        (r_dx),
        .i_dy        (r_dy),
        .o_addr      (w_pix_addr),
        .o_in_bounds (w_pix_in)
    );

    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        w_addr = '0;
        w_data = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_frame_end) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_we   = 1'b1;
                w_addr = r_clr_addr;
                if (r_clr_addr == LAST_ADDR) w_next = ST_DRAW;
            end
            ST_DRAW: begin
                w_we   = w_cur_v && w_pix_in;
                w_addr = w_pix_addr;
                w_data = 1'b1;
                if (w_last_pix && (r_idx == LAST_IDX)) w_next = ST_SWAP;
            end
            ST_SWAP: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_bx       <= '0;
            r_by       <= '0;
            r_bv       <= '0;
            r_clr_addr <= '0;
            r_idx      <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (i_frame_end && (r_state != ST_IDLE)) r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_end) begin
                        r_bx       <= i_boid_x;
                        r_by       <= i_boid_y;
                        r_bv       <= i_boid_valid;
                        r_clr_addr <= '0;
                        r_idx      <= '0;
                        r_dx       <= '0;
                        r_dy       <= '0;
                    end
                end
                ST_CLEAR: r_clr_addr <= r_clr_addr + 1'b1;
                ST_DRAW: begin
                    if (w_last_pix) begin
                        r_idx <= r_idx + 1'b1;
                        r_dx  <= '0;
                        r_dy  <= '0;
                    end else if (r_dx == LAST_D) begin
                        r_dx <= '0;
                        r_dy <= r_dy + 1'b1;
                    end else begin
                        r_dx <= r_dx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOID_DOUBLE_BUFFER_EN
    logic r_disp;

    always_ff @(posedge i_clock) begin
        if (i_reset)                   r_disp <= 1'b0;
        else if (r_state == ST_SWAP)   r_disp <= ~r_disp;
    end

    assign o_disp_buf = r_disp;
    assign o_fb_wbuf  = ~r_disp;
`else
    assign o_disp_buf = 1'b0;
    assign o_fb_wbuf  = 1'b0;
`endif

    assign o_fb_we      = w_we;
    assign o_fb_waddr   = w_addr;
    assign o_fb_wdata   = w_data;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_frame_done = w_done;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_boid_raster_engine.sv
// Directed scoreboard bench for boid_raster_engine on an 8x6 screen with two boids.
module tb_boid_raster_engine;

    localparam int NB = 2;
    localparam int BS = 2;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = $clog2(W * H);
`ifdef BOID_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_frame_end;
    logic [NB*10-1:0] i_boid_x;
    logic [NB*9-1:0]  i_boid_y;
    logic [NB-1:0]    i_boid_valid;
    logic             o_fb_we;
    logic [AW-1:0]    o_fb_waddr;
    logic             o_fb_wdata;
    logic             o_fb_wbuf;
    logic             o_disp_buf;
    logic             o_busy;
    logic             o_frame_done;
    logic             o_overrun;

    always #5 clk = ~clk;

    boid_raster_engine #(
        .MAX_BOIDS    (NB),
        .BOID_SIZE    (BS),
        .VIDEO_WIDTH  (W),
        .VIDEO_HEIGHT (H)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_frame_end  (i_frame_end),
        .i_boid_x     (i_boid_x),
        .i_boid_y     (i_boid_y),
        .i_boid_valid (i_boid_valid),
        .o_fb_we      (o_fb_we),
        .o_fb_waddr   (o_fb_waddr),
        .o_fb_wdata   (o_fb_wdata),
        .o_fb_wbuf    (o_fb_wbuf),
        .o_disp_buf   (o_disp_buf),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_overrun    (o_overrun)
    );

    typedef struct {
        int addr;
        int data;
        int wb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   n_done = 0;
    int   n_skip = 0;
    int   n_buf_hi = 0;
    int   n_idle_we = 0;
    int   span;
    int   found;
    logic exp_disp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // reference frame: full clear, then each valid boid's in-bounds pixels, dy outer / dx inner
    task automatic push_frame(input int x0, input int y0, input int x1, input int y1,
                              input logic [1:0] v);
        int xs[2];
        int ys[2];
        int wb;
        xs[0] = x0; xs[1] = x1; ys[0] = y0; ys[1] = y1;
        wb = DB ? int'(~exp_disp) : 0;
        for (int a = 0; a < W * H; a++) sb.push_back('{a, 0, wb});
        for (int i = 0; i < NB; i++)
            if (v[i])
                for (int dy = 0; dy < BS; dy++)
                    for (int dx = 0; dx < BS; dx++)
                        if (xs[i] + dx < W && ys[i] + dy < H)
                            sb.push_back('{(ys[i] + dy) * W + xs[i] + dx, 1, wb});
    endtask

    task automatic start_frame(input int x0, input int y0, input int x1, input int y1,
                               input logic [1:0] v);
        i_boid_x     = {10'(x1), 10'(x0)};
        i_boid_y     = {9'(y1), 9'(y0)};
        i_boid_valid = v;
        push_frame(x0, y0, x1, y1, v);
        n_done = 0;
        n_skip = 0;
        i_frame_end = 1'b1;
        @(negedge clk);
        i_frame_end  = 1'b0;
        i_boid_x     = NB*10'($urandom);
        i_boid_y     = NB*9'($urandom);
        i_boid_valid = ~v;
    endtask

    // span counts the frame_end cycle plus every busy cycle
    task automatic finish_frame(output int sp);
        int ok;
        ok = 0;
        sp = 1;
        for (int k = 0; k < 400; k++) begin
            if (!o_busy) begin
                ok = 1;
                break;
            end
            sp++;
            @(negedge clk);
        end
        chk("idle_timeout", ok, 1);
        if (DB) exp_disp = ~exp_disp;
        chk("disp_buf", o_disp_buf, exp_disp);
        chk("sb_leftover", sb.size(), 0);
        chk("frame_done_count", n_done, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_fb_we) begin
            if (sb.size() == 0) begin
                chk("write_unexpected", o_fb_waddr, 32'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("waddr", o_fb_waddr, e.addr);
                chk("wdata", o_fb_wdata, e.data);
                chk("wbuf", o_fb_wbuf, e.wb);
            end
        end
        if (o_fb_we && !o_busy) n_idle_we++;
        if (o_busy && !o_fb_we && !o_frame_done) n_skip++;
        if (o_frame_done) n_done++;
        if (o_disp_buf || o_fb_wbuf) n_buf_hi++;
    end

    initial begin
        i_reset      = 1'b1;
        i_frame_end  = 1'b0;
        i_boid_x     = '0;
        i_boid_y     = '0;
        i_boid_valid = '0;
        repeat (3) @(negedge clk);
        i_frame_end = 1'b1;
        @(negedge clk);
        chk("rst_busy_vs_frame_end", o_busy, 0);
        i_frame_end = 1'b0;
        i_reset     = 1'b0;
        @(negedge clk);
        chk("rst_fb_we", o_fb_we, 0);
        chk("rst_waddr", o_fb_waddr, 0);
        chk("rst_wdata", o_fb_wdata, 0);
        chk("rst_wbuf", o_fb_wbuf, DB ? 1 : 0);
        chk("rst_disp", o_disp_buf, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_overrun", o_overrun, 0);

        // two boids fully on screen
        start_frame(1, 1, 4, 2, 2'b11);
        finish_frame(span);
        chk("span_two_boids", span, 1 + 48 + 8 + 1);
        chk("skip_two_boids", n_skip, 0);

        // boid0 in the bottom-right corner: only 47 lands, three pixels skipped
        start_frame(7, 5, 4, 2, 2'b11);
        finish_frame(span);
        chk("skip_corner", n_skip, 3);

        // boid1 invalid: one idle slot
        start_frame(1, 1, 4, 2, 2'b01);
        finish_frame(span);
        chk("span_invalid", span, 1 + 48 + 4 + 1 + 1);
        chk("skip_invalid", n_skip, 1);

        // max coordinates must land off-screen rather than wrap to the origin
        start_frame(1023, 511, 7, 0, 2'b11);
        finish_frame(span);
        chk("skip_wrap", n_skip, 6);
        chk("overrun_clean", o_overrun, 0);

        // second frame_end during CLEAR is ignored apart from overrun
        start_frame(1, 1, 4, 2, 2'b11);
        repeat (10) @(negedge clk);
        i_frame_end = 1'b1;
        @(negedge clk);
        i_frame_end = 1'b0;
        finish_frame(span);
        chk("overrun_set", o_overrun, 1);
        repeat (5) @(negedge clk);
        chk("overrun_no_restart", o_busy, 0);
        chk("overrun_one_done", n_done, 1);
        chk("overrun_sticky", o_overrun, 1);

        // reset in the middle of CLEAR
        start_frame(1, 1, 4, 2, 2'b11);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (o_fb_we && o_fb_waddr == AW'(20)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("clear_addr20_seen", found, 1);
        i_reset = 1'b1;
        @(negedge clk);
        chk("abort_fb_we", o_fb_we, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_disp", o_disp_buf, 0);
        chk("abort_overrun", o_overrun, 0);
        sb.delete();
        exp_disp = 1'b0;
        i_reset  = 1'b0;
        @(negedge clk);

        // two back-to-back frames: buffers alternate, or stay 0 in single-buffer builds
        n_buf_hi = 0;
        start_frame(2, 3, 5, 0, 2'b11);
        finish_frame(span);
        start_frame(0, 0, 6, 4, 2'b10);
        finish_frame(span);
        if (!DB) chk("single_buf_zero", n_buf_hi, 0);

        chk("idle_writes", n_idle_we, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
